// File: rtl/axis_defs.sv
// Shared AXI-Stream sideband definitions.
// tuser_t carries the ingress descriptor (in.port, in.src) and a free-form meta field.
package axis_defs;

  localparam int unsigned PortW = 8;

  typedef struct packed {
    logic [PortW-1:0] port;
    logic [PortW-1:0] src;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [15:0] meta;
  } tuser_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with a registered ready.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   s_data_i/s_valid_i   upstream payload and valid
//   s_ready_o            upstream ready, a pure register output (no path from m_ready_i)
//   m_data_o/m_valid_o   downstream payload and valid, driven straight from the main register
//   m_ready_i            downstream ready
module axis_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [Width-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [Width-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;

  // Ready only depends on whether the spare entry is occupied.
  assign s_ready_o = ~skid_valid_q;
  assign m_data_o  = main_data_q;
  assign m_valid_o = main_valid_q;

  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || m_ready_i) begin
      // Main register is free this cycle: refill from skid first, else from the input.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = s_valid_i;
        if (s_valid_i) begin
          main_data_d = s_data_i;
        end
      end
    end else if (s_valid_i && s_ready_o) begin
      skid_data_d  = s_data_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/input_arbiter.sv
// Round-robin packet arbiter merging input_ports AXI-Stream inputs onto one output.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   s_axis_*[input_ports]      per-port input streams; s_axis_tready only for the granted port
//   m_axis_*                   merged stream, registered through axis_skid_buffer
//   pkt_count[input_ports]     per-port count of forwarded packets (wrapping)
// A whole packet is forwarded before re-arbitrating; tuser.in.port is replaced by the grant.
module input_arbiter
  import axis_defs::*;
#(
  parameter int unsigned input_ports      = 5,
  parameter int unsigned axis_data_width  = 256,
  parameter int unsigned axis_tkeep_width = axis_data_width / 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [axis_data_width-1:0]  s_axis_tdata  [input_ports],
  input  logic [axis_tkeep_width-1:0] s_axis_tkeep  [input_ports],
  input  tuser_t                      s_axis_tuser  [input_ports],
  input  logic                        s_axis_tlast  [input_ports],
  input  logic                        s_axis_tvalid [input_ports],
  output logic                        s_axis_tready [input_ports],
  output logic [axis_data_width-1:0]  m_axis_tdata,
  output logic [axis_tkeep_width-1:0] m_axis_tkeep,
  output tuser_t                      m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [31:0]                 pkt_count     [input_ports]
);

  localparam int unsigned PtrW     = (input_ports > 1) ? $clog2(input_ports) : 1;
  localparam int unsigned PayloadW = axis_data_width + axis_tkeep_width + $bits(tuser_t) + 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                         state_q, state_d;
  logic [PtrW-1:0]                grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [input_ports-1:0][31:0]   cnt_q, cnt_d;
  logic [input_ports-1:0]         valid_vec;
  logic                           locked, buf_ready, in_valid, accept;
  tuser_t                         sel_user;
  logic [PayloadW-1:0]            in_payload, out_payload;

  // First set bit of vld at or after ptr, wrapping at input_ports.
  function automatic logic [PtrW-1:0] pick_port(input logic [input_ports-1:0] vld,
                                                 input logic [PtrW-1:0]        ptr);
    logic [2*input_ports-1:0] rot;
    logic [PtrW:0]            idx;
    logic                     found;
    pick_port = '0;
    found     = 1'b0;
    idx       = '0;
    rot       = {vld, vld} >> ptr;
    for (int unsigned i = 0; i < input_ports; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = {1'b0, ptr} + (PtrW+1)'(i);
        if (idx >= (PtrW+1)'(input_ports)) begin
          idx = idx - (PtrW+1)'(input_ports);
        end
        pick_port = idx[PtrW-1:0];
      end
    end
  endfunction

  assign locked   = (state_q == StLocked);
  assign in_valid = locked & s_axis_tvalid[grant_q];
  assign accept   = in_valid & buf_ready;

  always_comb begin
    for (int p = 0; p < int'(input_ports); p++) begin
      valid_vec[p]     = s_axis_tvalid[p];
      s_axis_tready[p] = locked && buf_ready && (grant_q == PtrW'(p));
      pkt_count[p]     = cnt_q[p];
    end
  end

  always_comb begin
    sel_user         = s_axis_tuser[grant_q];
    sel_user.in.port = PortW'(grant_q);
  end

  assign in_payload = {s_axis_tdata[grant_q], s_axis_tkeep[grant_q], sel_user,
                       s_axis_tlast[grant_q]};

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|valid_vec) begin
          grant_d = pick_port(valid_vec, rr_ptr_q);
          state_d = StLocked;
        end
      end
      StLocked: begin
        // Stay locked through tvalid gaps; release only on the accepted tlast beat.
        if (accept && s_axis_tlast[grant_q]) begin
          state_d        = StIdle;
          rr_ptr_d       = (grant_q == PtrW'(input_ports - 1)) ? '0 : grant_q + 1'b1;
          cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  axis_skid_buffer #(
    .Width(PayloadW)
  ) u_skid (
    .clk_i    (clk),
    .rst_i    (reset),
    .s_data_i (in_payload),
    .s_valid_i(in_valid),
    .s_ready_o(buf_ready),
    .m_data_o (out_payload),
    .m_valid_o(m_axis_tvalid),
    .m_ready_i(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_payload;

endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter: single packet, round robin, backpressure,
// mid-packet gap with a competitor, counter wrap and mid-packet reset.
module tb_input_arbiter;
  import axis_defs::*;

  localparam int NP = 5;
  localparam int DW = 256;
  localparam int KW = 32;

  // Beat word: {gap_after, last, data32}
  typedef logic [33:0] word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] s_tdata [NP];
  logic [KW-1:0] s_tkeep [NP];
  tuser_t        s_tuser [NP];
  logic          s_tlast [NP];
  logic          s_tvalid[NP];
  logic          s_tready[NP];
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  tuser_t        m_tuser;
  logic          m_tlast, m_tvalid;
  logic          m_tready = 1'b1;
  logic [31:0]   pkt_count[NP];

  input_arbiter #(
    .input_ports(NP),
    .axis_data_width(DW),
    .axis_tkeep_width(KW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tuser (s_tuser),
    .s_axis_tlast (s_tlast),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tuser (m_tuser),
    .m_axis_tlast (m_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int pkt_seq = 0;

  word_t       src_q  [NP][$];
  word_t       exp_src[NP][$];
  logic [41:0] exp_q[$];
  int          hold[NP] = '{default: 0};
  logic        acc [NP] = '{default: 1'b0};

  logic [31:0] out_data[$], out_keep[$];
  logic [7:0]  out_port[$], out_src[$];
  logic [15:0] out_meta[$];
  logic        out_last[$];
  int          out_cyc[$], in_cyc[$];

  logic [NP-1:0] rdy_vec;
  logic [DW-1:0] prev_data;
  tuser_t        prev_user;
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_last = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Source driver: presents the head of each port queue, pops on acceptance.
  task automatic drive_port(input int p);
    word_t w;
    if (src_q[p].size() > 0 && hold[p] == 0) begin
      w = src_q[p][0];
      s_tvalid[p]        = 1'b1;
      s_tdata[p]         = {8{w[31:0]}};
      s_tkeep[p]         = w[31:0];
      s_tlast[p]         = w[32];
      s_tuser[p].in.port = 8'hEE;
      s_tuser[p].in.src  = 8'(p);
      s_tuser[p].meta    = w[15:0];
    end else begin
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
    end
  endtask

  initial begin
    word_t dw;
    for (int p = 0; p < NP; p++) begin
      s_tdata[p] = '0; s_tkeep[p] = '0; s_tuser[p] = '0; s_tlast[p] = 1'b0; s_tvalid[p] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p] && src_q[p].size() > 0) begin
          dw = src_q[p].pop_front();
          hold[p] = dw[33] ? 3 : 0;
        end else if (hold[p] > 0) begin
          hold[p]--;
        end
        drive_port(p);
      end
    end
  end

  // Monitor on the falling edge: records transfers that the next rising edge completes.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      acc[p]     = s_tvalid[p] & s_tready[p];
      rdy_vec[p] = s_tready[p];
      if (acc[p]) in_cyc.push_back(cyc);
    end
    check_eq("tready_onehot", 256'($countones(rdy_vec) <= 1), 256'd1);
    if (prev_v && !prev_r && !reset) begin
      check_eq("hold_valid", m_tvalid, 1'b1);
      check_eq("hold_data", m_tdata, prev_data);
      check_eq("hold_user", m_tuser, prev_user);
      check_eq("hold_last", m_tlast, prev_last);
    end
    if (m_tvalid && m_tready) begin
      out_data.push_back(m_tdata[31:0]);
      out_keep.push_back(m_tkeep);
      out_port.push_back(m_tuser.in.port);
      out_src.push_back(m_tuser.in.src);
      out_meta.push_back(m_tuser.meta);
      out_last.push_back(m_tlast);
      out_cyc.push_back(cyc);
    end
    prev_v = m_tvalid; prev_r = m_tready; prev_data = m_tdata;
    prev_user = m_tuser; prev_last = m_tlast;
  end

  task automatic push_pkt(input int p, input int n, input int gap_after);
    word_t w;
    for (int b = 0; b < n; b++) begin
      w = {(b == gap_after), (b == n - 1), 8'(p), 8'(pkt_seq), 16'(b)};
      src_q[p].push_back(w);
      exp_src[p].push_back(w);
    end
    pkt_seq++;
  endtask

  task automatic expect_pkt(input int p);
    word_t w;
    w = '0;
    while (exp_src[p].size() > 0 && !w[32]) begin
      w = exp_src[p].pop_front();
      exp_q.push_back({8'(p), w});
    end
  endtask

  task automatic clear_outs();
    out_data.delete(); out_keep.delete(); out_port.delete(); out_src.delete();
    out_meta.delete(); out_last.delete(); out_cyc.delete(); in_cyc.delete(); exp_q.delete();
  endtask

  task automatic clear_srcs();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete(); exp_src[p].delete(); hold[p] = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    logic [41:0] e;
    check_eq({tag, "_count"}, 256'(out_data.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_data.size(); i++) begin
      e = exp_q[i];
      check_eq({tag, "_data"}, out_data[i], e[31:0]);
      check_eq({tag, "_keep"}, out_keep[i], e[31:0]);
      check_eq({tag, "_last"}, out_last[i], e[32]);
      check_eq({tag, "_port"}, out_port[i], e[41:34]);
      check_eq({tag, "_src"}, out_src[i], e[41:34]);
      check_eq({tag, "_meta"}, out_meta[i], e[15:0]);
    end
  endtask

  task automatic wait_outs(input int n, input int budget);
    for (int i = 0; i < budget && out_data.size() < n; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic reset_on();
    @(posedge clk);
    #2;
    reset = 1'b1;
    clear_srcs();
    clear_outs();
  endtask

  task automatic reset_off();
    @(posedge clk);
    #2;
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    // Single 3-beat packet on port 2, queued while still in reset.
    push_pkt(2, 3, -1);
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_mvalid", m_tvalid, 1'b0);
    check_eq("rst_tdata", m_tdata, '0);
    check_eq("rst_tuser", m_tuser, '0);
    check_eq("rst_tlast", m_tlast, 1'b0);
    check_eq("rst_tready", rdy_vec, '0);
    check_eq("rst_svalid2", s_tvalid[2], 1'b1);
    for (int p = 0; p < NP; p++) check_eq("rst_cnt", pkt_count[p], 32'd0);
    reset_off();
    wait_outs(3, 50);
    expect_pkt(2);
    check_outs("t1");
    if (in_cyc.size() > 0 && out_cyc.size() > 0) begin
      check_eq("t1_arb_cycle", 256'(in_cyc[0]), 256'(rel_cyc + 1));
      check_eq("t1_latency", 256'(out_cyc[0]), 256'(in_cyc[0] + 1));
    end
    check_eq("t1_cnt2", pkt_count[2], 32'd1);
    check_eq("t1_cnt0", pkt_count[0], 32'd0);

    // Round robin: every port holds two 2-beat packets.
    reset_on();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_pkt(p, 2, -1);
    reset_off();
    wait_outs(20, 200);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) expect_pkt(p);
    check_outs("t2");
    for (int i = 1; i < out_cyc.size(); i++)
      check_eq("t2_spacing", 256'(out_cyc[i] - out_cyc[i-1]), 256'((i % 2 == 0) ? 2 : 1));
    for (int p = 0; p < NP; p++) check_eq("t2_cnt", pkt_count[p], 32'd2);

    // Backpressure 1,0,0,1 on a 4-beat packet from port 0.
    clear_outs();
    push_pkt(0, 4, -1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (m_tvalid) seen = 1'b1;
    end
    @(posedge clk); #2; m_tready = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2; m_tready = 1'b1;
    wait_outs(4, 50);
    expect_pkt(0);
    check_outs("t3");
    if (out_cyc.size() > 1) check_eq("t3_stall", 256'(out_cyc[1] - out_cyc[0]), 256'd3);
    check_eq("t3_cnt0", pkt_count[0], 32'd3);

    // Port 1 pauses mid-packet while port 3 waits.
    clear_outs();
    push_pkt(1, 4, 1);
    push_pkt(3, 2, -1);
    wait_outs(6, 100);
    expect_pkt(1);
    expect_pkt(3);
    check_outs("t4");
    if (out_cyc.size() > 2) check_eq("t4_gap", 256'(out_cyc[2] - out_cyc[1]), 256'd4);

    // Counter wrap with single-beat packets on port 0.
    reset_on();
    reset_off();
    force dut.cnt_q = {128'd0, 32'hFFFF_FFFF};
    repeat (2) @(posedge clk);
    release dut.cnt_q;
    #2;
    push_pkt(0, 1, -1);
    wait_outs(1, 50);
    expect_pkt(0);
    check_outs("t5");
    check_eq("t5_wrap", pkt_count[0], 32'd0);
    check_eq("t5_cnt1", pkt_count[1], 32'd0);
    push_pkt(0, 1, -1);
    wait_outs(2, 50);
    check_eq("t5_second", pkt_count[0], 32'd1);

    // Reset in the middle of a stalled packet.
    clear_outs();
    m_tready = 1'b0;
    push_pkt(2, 6, -1);
    for (int i = 0; i < 30 && in_cyc.size() < 2; i++) @(negedge clk);
    @(negedge clk);
    check_eq("t6_pre_valid", m_tvalid, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("t6_mvalid", m_tvalid, 1'b0);
    check_eq("t6_tdata", m_tdata, '0);
    check_eq("t6_tuser", m_tuser, '0);
    check_eq("t6_tlast", m_tlast, 1'b0);
    check_eq("t6_tready", rdy_vec, '0);
    check_eq("t6_state", dut.state_q, 1'b0);
    check_eq("t6_cnt2", pkt_count[2], 32'd0);
    clear_srcs();
    clear_outs();
    @(posedge clk);
    #2;
    reset = 1'b0;
    m_tready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check_eq("t6_no_emit", 256'(out_data.size()), 256'd0);
    check_eq("t6_cnt_after", pkt_count[2], 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
